// File: rtl/jt7759_rom_bridge.sv
// Byte-wide ROM responder for the JT7759 controller, backed by a 16-bit memory port.
// Two word entries: E0 holds the demand word, E1 the prefetched next word.
module jt7759_rom_bridge #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-2:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_dout
);
  localparam int TW = AW - 1;
  localparam logic [TW-1:0] TAG_ONE = TW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PREF  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            req_reg, req_next;
  logic [TW-1:0]   maddr_reg, maddr_next;
  logic            drop_reg, drop_next;

  logic [1:0]      ent_valid_reg, ent_valid_next;
  logic [TW-1:0]   ent_tag_reg  [2];
  logic [TW-1:0]   ent_tag_next [2];
  logic [15:0]     ent_data_reg [2];
  logic [15:0]     ent_data_next[2];

  logic            ok_r, ok_next;
  logic [AW-1:0]   addr_r, addr_next;
  logic [7:0]      data_r, rdata_next;

  logic [TW-1:0]   word;
  logic [1:0]      hit;
  logic [TW-1:0]   pref0, pref1, maddr_inc;

  assign word      = rom_addr[AW-1:1];
  assign pref0     = ent_tag_reg[0] + TAG_ONE;
  assign pref1     = ent_tag_reg[1] + TAG_ONE;
  assign maddr_inc = maddr_reg + TAG_ONE;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign hit[gi] = rom_cs & ent_valid_reg[gi] & (ent_tag_reg[gi] == word);
    end
  endgenerate

  function automatic logic [7:0] pick(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

  assign rom_data = data_r;
  assign rom_ok   = ok_r & rom_cs & (rom_addr == addr_r);
  assign mem_req  = req_reg;
  assign mem_addr = maddr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      maddr_reg     <= '0;
      drop_reg      <= 1'b0;
      ent_valid_reg <= '0;
      for (int i = 0; i < 2; i++) begin
        ent_tag_reg[i]  <= '0;
        ent_data_reg[i] <= '0;
      end
      ok_r   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      maddr_reg     <= maddr_next;
      drop_reg      <= drop_next;
      ent_valid_reg <= ent_valid_next;
      for (int i = 0; i < 2; i++) begin
        ent_tag_reg[i]  <= ent_tag_next[i];
        ent_data_reg[i] <= ent_data_next[i];
      end
      ok_r   <= ok_next;
      addr_r <= addr_next;
      data_r <= rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    req_next       = req_reg;
    maddr_next     = maddr_reg;
    drop_next      = drop_reg;
    ent_valid_next = ent_valid_reg;
    ent_tag_next   = ent_tag_reg;
    ent_data_next  = ent_data_reg;
    ok_next        = ok_r;
    addr_next      = addr_r;
    rdata_next     = data_r;

    // E0 hits are served in every state; E0 is never rewritten while PREF is pending.
    if (hit[0] && !flush) begin
      ok_next    = 1'b1;
      addr_next  = rom_addr;
      rdata_next = pick(ent_data_reg[0], rom_addr[0]);
    end

    case (state_reg)
      IDLE: begin
        if (!hit[0] && !flush) begin
          if (hit[1]) begin
            ent_valid_next   = 2'b01;
            ent_tag_next[0]  = ent_tag_reg[1];
            ent_data_next[0] = ent_data_reg[1];
            ok_next          = 1'b1;
            addr_next        = rom_addr;
            rdata_next       = pick(ent_data_reg[1], rom_addr[0]);
            if (pref1 != ent_tag_reg[1]) begin
              state_next = PREF;
              req_next   = 1'b1;
              maddr_next = pref1;
            end
          end else if (rom_cs) begin
            state_next = FETCH;
            req_next   = 1'b1;
            maddr_next = word;
          end else if (ent_valid_reg == 2'b01 && pref0 != ent_tag_reg[0]) begin
            state_next = PREF;
            req_next   = 1'b1;
            maddr_next = pref0;
          end
        end
      end
      FETCH: begin
        if (mem_ack) begin
          if (flush || drop_reg) begin
            state_next = IDLE;
            req_next   = 1'b0;
            drop_next  = 1'b0;
          end else begin
            ent_valid_next[0] = 1'b1;
            ent_tag_next[0]   = maddr_reg;
            ent_data_next[0]  = mem_dout;
            // The controller may have moved on; only answer the address it shows now.
            if (rom_cs && word == maddr_reg) begin
              ok_next    = 1'b1;
              addr_next  = rom_addr;
              rdata_next = pick(mem_dout, rom_addr[0]);
            end
            if (maddr_inc != maddr_reg) begin
              state_next = PREF;
              req_next   = 1'b1;
              maddr_next = maddr_inc;
            end else begin
              state_next = IDLE;
              req_next   = 1'b0;
            end
          end
        end
      end
      PREF: begin
        if (mem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
          if (flush || drop_reg) begin
            drop_next = 1'b0;
          end else begin
            ent_valid_next[1] = 1'b1;
            ent_tag_next[1]   = maddr_reg;
            ent_data_next[1]  = mem_dout;
          end
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    // Bus requests cannot be withdrawn, so a flush marks the in-flight word for discard.
    if (flush) begin
      ent_valid_next = '0;
      ok_next        = 1'b0;
      if (state_reg != IDLE && !mem_ack) drop_next = 1'b1;
    end
  end
endmodule

// File: tb/tb_jt7759_rom_bridge.sv
// Directed bench for jt7759_rom_bridge: a latency-programmable memory responder plus
// scoreboards of expected read bytes and expected memory word addresses.
module tb_jt7759_rom_bridge;
  logic        clk;
  logic        rst;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        flush;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        resp_ack;
  logic [15:0] resp_dout;
  logic        stray_ack;
  logic [15:0] stray_dout;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int req_count = 0;
  bit busy = 0;
  int wait_n = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] req_exp_q[$];

  jt7759_rom_bridge #(.AW(17)) dut (
    .clk      (clk),
    .rst      (rst),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (resp_ack | stray_ack),
    .mem_dout (stray_ack ? stray_dout : resp_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] w);
    if (w == 16'h0001) return 16'hA55A;
    return {w[7:0] ^ 8'h3C, w[15:8] ^ 8'hC5} + 16'h0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks each request after `lat` cycles and checks its address.
  always @(negedge clk) begin
    logic [31:0] exp_a;
    if (resp_ack) begin
      resp_ack = 1'b0;
      busy     = 1'b0;
    end
    if (rst || !mem_req) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy   = 1'b1;
        wait_n = 0;
        req_count++;
        exp_a = (req_exp_q.size() != 0) ? {16'h0, req_exp_q.pop_front()} : 32'hFFFF_FFFF;
        chk("req_addr", {16'h0, mem_addr}, exp_a);
      end
      if (wait_n == lat) begin
        resp_ack  = 1'b1;
        resp_dout = mem_word(mem_addr);
      end
      wait_n++;
    end
  end

  task automatic rd(input logic [16:0] a, input int exp_lat);
    logic [15:0] w;
    int k;
    w = mem_word(a[16:1]);
    exp_q.push_back(a[0] ? w[15:8] : w[7:0]);
    rom_addr = a;
    rom_cs   = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rom_ok && k < 100);
    chk("rom_ok_seen", {31'h0, rom_ok}, 32'h1);
    if (exp_lat > 0) chk("read_latency", k, exp_lat);
    chk("rom_data", {24'h0, rom_data}, {24'h0, exp_q.pop_front()});
    $display("read addr=%05h data=%02h cycles=%0d", a, rom_data, k);
    rom_cs = 1'b0;
    #1;
    chk("cs_low_ok", {31'h0, rom_ok}, 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int q;
    q = 0;
    for (int k = 0; k < 500 && q < 3; k++) begin
      @(negedge clk);
      if (!mem_req) q++;
      else q = 0;
    end
    chk(tag, {31'h0, q >= 3}, 32'h1);
    chk({tag, "_reqs_done"}, req_exp_q.size(), 32'h0);
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!mem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'h0, mem_req}, 32'h1);
  endtask

  initial begin
    #300000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    int rc;
    int k;
    bit held;
    rst        = 1'b1;
    rom_cs     = 1'b0;
    rom_addr   = '0;
    flush      = 1'b0;
    resp_ack   = 1'b0;
    resp_dout  = '0;
    stray_ack  = 1'b0;
    stray_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_rom_ok", {31'h0, rom_ok}, 32'h0);
    chk("rst_rom_data", {24'h0, rom_data}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss: latency 5, expect byte 0xA5 and a prefetch of word 2.
    lat = 5;
    req_exp_q.push_back(16'h0001);
    req_exp_q.push_back(16'h0002);
    rd(17'h00003, 7);
    wait_idle("cold_idle");

    // CS pulse on a held address: served from E0 with no bus traffic.
    rc = req_count;
    rd(17'h00002, 1);
    rd(17'h00002, 1);
    chk("cs_pulse_no_req", req_count - rc, 32'h0);

    // Sequential stream across 8 words plus one lookahead.
    lat = 2;
    for (int i = 0; i < 9; i++) req_exp_q.push_back(16'h0080 + 16'(i));
    rc = req_count;
    rd(17'h00100, 4);
    for (int i = 1; i < 16; i++) rd(17'h00100 + 17'(i), 1);
    wait_idle("stream_idle");
    chk("stream_req_count", req_count - rc, 32'd9);

    // Wrap: word 0xFFFF upper byte, prefetch wraps to word 0.
    lat = 1;
    req_exp_q.push_back(16'hFFFF);
    req_exp_q.push_back(16'h0000);
    rd(17'h1FFFF, 3);
    wait_idle("wrap_idle");

    // Flush while word 0x40 is in flight: request held, word discarded.
    lat = 5;
    req_exp_q.push_back(16'h0040);
    req_exp_q.push_back(16'h0040);
    req_exp_q.push_back(16'h0041);
    rom_addr = 17'h00080;
    rom_cs   = 1'b1;
    @(negedge clk);
    wait_req("flush_req_up");
    rom_cs = 1'b0;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    held  = 1'b1;
    k     = 0;
    do begin
      @(negedge clk);
      #1;
      if (!mem_req) held = 1'b0;
      k++;
    end while (!resp_ack && k < 50);
    chk("flush_req_held", {31'h0, held}, 32'h1);
    chk("flush_ack_seen", {31'h0, resp_ack}, 32'h1);
    @(negedge clk);
    #1;
    chk("flush_discard_idle", {31'h0, mem_req}, 32'h0);
    lat = 3;
    rd(17'h00080, 5);
    wait_idle("flush_idle");

    // Demand miss while prefetch 0x21 is pending waits for its ack.
    lat = 8;
    req_exp_q.push_back(16'h0020);
    req_exp_q.push_back(16'h0021);
    req_exp_q.push_back(16'h0800);
    req_exp_q.push_back(16'h0801);
    rd(17'h00040, 10);
    rd(17'h01000, 0);
    wait_idle("demand_idle");

    // Asynchronous reset in FETCH, then a stray ack that must be ignored.
    lat = 8;
    req_exp_q.push_back(16'h1000);
    rom_addr = 17'h02000;
    rom_cs   = 1'b1;
    @(negedge clk);
    wait_req("rst_req_up");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("async_rst_rom_ok", {31'h0, rom_ok}, 32'h0);
    chk("async_rst_rom_data", {24'h0, rom_data}, 32'h0);
    chk("async_rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    rom_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stray_dout = 16'hBEEF;
    stray_ack  = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("stray_ack_no_req", {31'h0, mem_req}, 32'h0);
    lat = 2;
    req_exp_q.push_back(16'h1000);
    req_exp_q.push_back(16'h1001);
    rd(17'h02000, 4);
    wait_idle("final_idle");
    chk("read_queue_empty", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jt7759_rom_bridge.md
# jt7759_rom_bridge

ROM-side responder for the JT7759 control FSM: serves the byte-wide `rom_cs`/`rom_addr`/`rom_data`/`rom_ok` interface from a 16-bit-wide, variable-latency memory bus (SDRAM/BRAM arbiter port). It keeps a two-word buffer: one demand word plus one prefetched next word. Sequential ADPCM nibble streams and header reads therefore mostly hit without waiting on the memory bus. It sits between `jt7759` and the system memory arbiter.

## Interface

Parameters:
- `AW`, default 17: byte address width; the memory word address is `AW-1` bits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_cs`  in  1  read request from the controller; the controller drops it for ≥1 cycle between addresses.
- `rom_addr`  in  AW  byte address.
- `rom_data`  out  8  byte at the latched address.
- `rom_ok`  out  1  `rom_data` is valid for the current `rom_addr`.
- `flush`  in  1  invalidates the buffer (ROM bank change).
- `mem_req`  out  1  memory request; held high until acknowledged.
- `mem_addr`  out  AW-1  word address, stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_dout` is valid in the same cycle.
- `mem_dout`  in  16  memory word; byte 0 (`rom_addr[0]=0`) is `[7:0]`, byte 1 is `[15:8]`.

## Operation

- **Buffer entries**
  - E0 (demand) and E1 (prefetch), each holding {valid, tag[AW-2:0], data[15:0]}.
  - Hit: `rom_cs` is high and `rom_addr[AW-1:1]` equals a valid tag.
- **FSM states**
  - IDLE: no memory request outstanding.
  - FETCH: demand request outstanding.
  - PREF: prefetch request outstanding.
- **IDLE**
  - `rom_cs` high, hit E0: latch the byte; no memory access.
  - `rom_cs` high, hit E1 only: copy E1 into E0, invalidate E1, latch the byte, then go to PREF with tag+1.
  - `rom_cs` high, miss: go to FETCH with `mem_addr = rom_addr[AW-1:1]`.
  - `rom_cs` low, E0 valid, E1 invalid: go to PREF with `E0.tag+1`.
- **FETCH**
  - On `mem_ack`: write E0, latch the byte if the address still matches, then go to PREF with tag+1.
- **PREF**
  - On `mem_ack`: write E1, return to IDLE.
  - A demand miss during PREF waits; bus requests are never cancelled.
  - After the prefetch ack, the miss is re-evaluated in IDLE; it may now hit E1.
- **Prefetch address arithmetic**
  - Modulo 2^(AW-1): tag all-ones wraps to 0.
  - No prefetch is issued if the target tag equals the E0 tag.
- **Output qualification**
  - Internal registers: `ok_r`, `addr_r`, `data_r`.
  - `rom_ok = ok_r & rom_cs & (rom_addr == addr_r)`. The controller's cs-low pulse therefore always drops `rom_ok` in the same cycle.
- **flush**
  - Clears both valid bits and `ok_r`.
  - If a request is in flight, `mem_req` stays high until `mem_ack`; the returned word is discarded and the FSM goes to IDLE.
  - A flush coinciding with `mem_ack` also discards the word.
- **Simultaneous events**
  - `mem_ack` and an address change in the same cycle: the word is stored; the byte is latched only if its tag matches the new address.
  - Otherwise the new address is re-evaluated next cycle.

## Timing

- **Reset values:** `rom_data=0`, `rom_ok=0`, `mem_req=0`, `mem_addr=0`, both entries invalid, FSM in IDLE.
- **Reset mid-request:** `mem_req` drops immediately (asynchronous); a later stray `mem_ack` in IDLE is ignored.
- **Hit latency:** address presented with `rom_cs` high at cycle N → `rom_ok`=1 at N+1.
- **Miss latency:**
  - Miss detected at N → `mem_req`=1 at N+1.
  - `mem_ack` at M → `rom_ok`=1 at M+1.
- **Prefetch issue:** `mem_req` rises one cycle after the demand ack (FETCH→PREF), or one cycle after an E1 promotion.
- **Stability:** `rom_data` changes only when `ok_r` is re-latched; it holds its value while `rom_ok` is low.
- **Throughput:** sequential bytes within the buffered words need no memory access. Exactly one memory request is in flight at a time.

## Test plan

- **Cold miss:** reset, `rom_cs=1`, `rom_addr=0x00003`, memory latency 5, word 0x0001 = 0xA55A → `mem_addr=0x0001`; `rom_ok` 6 cycles after `mem_req`; `rom_data=0xA5`; a prefetch of 0x0002 follows.
- **Sequential stream:** bytes 0x00100 through 0x0010F with a cs-low pulse between reads, after prefetch completes → every byte returns `rom_ok` 1 cycle after cs rises. Exactly 9 memory requests in total (8 words + 1 lookahead).
- **CS pulse:** hold `rom_addr`, drop `rom_cs` for 1 cycle → `rom_ok`=0 in that cycle and 1 on the cycle after cs returns; no new `mem_req`.
- **Wrap:** read `rom_addr=0x1FFFF` → `rom_data=mem_dout[15:8]` of word 0xFFFF; prefetch `mem_addr=0x0000`.
- **Flush in flight:** assert `flush` during an outstanding request for word 0x0040 → `mem_req` held until ack, data discarded; the next read of 0x00080 issues a fresh request.
- **Demand during prefetch and reset:**
  - Miss to 0x01000 while prefetch 0x0021 is pending → demand request is issued only after the prefetch ack.
  - Async reset during FETCH → `mem_req`=0 and `rom_ok`=0 immediately.
